// File: rtl/preg_reclaim_pkg.sv
// Shared types, defaults and helpers for the physical-register reclaim path.
package preg_reclaim_pkg;

    localparam int DEF_MAX_LENGTH = 64;
    localparam int DEF_MAX_IO     = 3;
    localparam int DEF_IO_WIDTH   = 6;
    localparam int ML_BITS        = $clog2(DEF_MAX_LENGTH);

    typedef logic [DEF_IO_WIDTH-1:0] preg_t;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/preg_reclaim_if.sv
// Retire-side and free-list-side signal bundle of preg_reclaim.
interface preg_reclaim_if
    import preg_reclaim_pkg::*;
#(
    parameter int MAX_LENGTH  = DEF_MAX_LENGTH,
    parameter int IO_WIDTH    = DEF_IO_WIDTH,
    parameter int MAX_IO      = DEF_MAX_IO,
    parameter int STAGE_DEPTH = 8
);
    localparam int FL_BITS = $clog2(MAX_LENGTH);
    localparam int SC_BITS = $clog2(STAGE_DEPTH) + 1;

    logic [MAX_IO-1:0]               retire_en;
    logic [MAX_IO-1:0][IO_WIDTH-1:0] retire_tag;
    logic                            retire_ready;
    logic [FL_BITS:0]                fl_len;
    logic [MAX_IO-1:0]               put_en;
    logic [MAX_IO-1:0][IO_WIDTH-1:0] put;
    logic [SC_BITS-1:0]              stage_count;
    logic                            overflow_err;

    modport slave (
        input  retire_en, retire_tag, fl_len,
        output retire_ready, put_en, put, stage_count, overflow_err
    );

    modport master (
        output retire_en, retire_tag, fl_len,
        input  retire_ready, put_en, put, stage_count, overflow_err
    );

endinterface

// File: rtl/preg_reclaim_lane_compact.sv
// Prefix-sum lane compaction: each enabled lane gets its dense slot offset.
module lane_compact #(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         en_i,
    output logic [N-1:0][CW-1:0] off_o,
    output logic [CW-1:0]        cnt_o
);

    logic [CW-1:0] run_s;

    // Exclusive running sum of enables gives each lane's offset.
    always_comb begin
        run_s = '0;
        off_o = '0;
        for (int i = 0; i < N; i++) begin
            off_o[i] = run_s;
            run_s    = run_s + CW'(en_i[i]);
        end
        cnt_o = run_s;
    end

endmodule

// File: rtl/preg_reclaim.sv
// Producer side of the multi-lane free list: stages retired tags, drains them in order.
// Optional same-cycle bypass of an empty staging buffer: PREG_RECLAIM_BYPASS_EN.
module preg_reclaim
    import preg_reclaim_pkg::*;
#(
    parameter int MAX_LENGTH  = DEF_MAX_LENGTH,
    parameter int IO_WIDTH    = DEF_IO_WIDTH,
    parameter int MAX_IO      = DEF_MAX_IO,
    parameter int STAGE_DEPTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    preg_reclaim_if.slave bus
);

    localparam int PW  = $clog2(STAGE_DEPTH);
    localparam int SCW = PW + 1;
    localparam int CW  = $clog2(MAX_IO + 1);

    generate
        if ((STAGE_DEPTH <= 0) || ((STAGE_DEPTH & (STAGE_DEPTH - 1)) != 0)
            || (STAGE_DEPTH < MAX_IO)) begin : g_bad_cfg
            $error("preg_reclaim: STAGE_DEPTH must be a power of two and >= MAX_IO");
        end
    endgenerate

    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [SCW-1:0] stage_count_q, stage_count_d;
    logic           overflow_q, overflow_d;
    logic           ready_q, ready_d;
    logic [IO_WIDTH-1:0] mem_q [STAGE_DEPTH];

    logic [MAX_IO-1:0][CW-1:0]       off_s;
    logic [CW-1:0]                   ret_cnt_s;
    logic [MAX_IO-1:0][IO_WIDTH-1:0] comp_tag_s;
    logic [MAX_IO-1:0]               put_en_s;
    logic [MAX_IO-1:0][IO_WIDTH-1:0] put_s;
    logic [MAX_IO-1:0]               wr_en_s;
    logic [MAX_IO-1:0][PW-1:0]       wr_idx_s;
    logic [PW-1:0]                   rd_idx_s;
    logic                            bypass_s;
    int                              free_s, acc_s, n_s, skip_s;

    lane_compact #(.N(MAX_IO), .CW(CW)) u_compact (
        .en_i  (bus.retire_en),
        .off_o (off_s),
        .cnt_o (ret_cnt_s)
    );

    // Dense list of this cycle's retired tags, used only for bypass.
    always_comb begin
        comp_tag_s = '0;
        for (int j = 0; j < MAX_IO; j++) begin
            for (int i = 0; i < MAX_IO; i++) begin
                if (bus.retire_en[i] && (off_s[i] == CW'(j))) begin
                    comp_tag_s[j] = bus.retire_tag[i];
                end else begin
                    comp_tag_s[j] = comp_tag_s[j];
                end
            end
        end
    end

    // Drain sizing, put lanes, staging writes and next-state pointers.
    always_comb begin
        acc_s = ready_q ? int'(ret_cnt_s) : 0;
        if (int'(bus.fl_len) > MAX_LENGTH) begin
            free_s = 0;
        end else begin
            free_s = MAX_LENGTH - int'(bus.fl_len);
        end

        bypass_s = 1'b0;
`ifdef PREG_RECLAIM_BYPASS_EN
        // Reset gating keeps put quiet while rst_n is low even with live retires.
        if (rst_n && ready_q && (stage_count_q == '0)) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
`endif

        if (bypass_s) begin
            n_s = min3(acc_s, MAX_IO, free_s);
        end else begin
            n_s = min3(int'(stage_count_q), MAX_IO, free_s);
        end
        skip_s = bypass_s ? n_s : 0;

        put_en_s = '0;
        put_s    = '0;
        rd_idx_s = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            rd_idx_s = head_q + PW'(i);
            if (i < n_s) begin
                put_en_s[i] = 1'b1;
                put_s[i]    = bypass_s ? comp_tag_s[i] : mem_q[rd_idx_s];
            end else begin
                put_en_s[i] = 1'b0;
                put_s[i]    = '0;
            end
        end

        // Bypassed tags are skipped; the rest land at the tail in order.
        wr_en_s  = '0;
        wr_idx_s = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            if (ready_q && bus.retire_en[i] && (int'(off_s[i]) >= skip_s)) begin
                wr_en_s[i]  = 1'b1;
                wr_idx_s[i] = tail_q + PW'(int'(off_s[i]) - skip_s);
            end else begin
                wr_en_s[i]  = 1'b0;
                wr_idx_s[i] = '0;
            end
        end

        head_d        = bypass_s ? head_q : (head_q + PW'(n_s));
        tail_d        = tail_q + PW'(acc_s - skip_s);
        stage_count_d = SCW'(int'(stage_count_q) + acc_s - n_s);
        overflow_d    = overflow_q | (~ready_q & (|bus.retire_en));
        ready_d       = ((STAGE_DEPTH - int'(stage_count_d)) >= MAX_IO);
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            stage_count_q <= '0;
            overflow_q    <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            stage_count_q <= stage_count_d;
            overflow_q    <= overflow_d;
            ready_q       <= ready_d;
        end
    end

    // Staging storage; contents are meaningless outside head..tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_IO; i++) begin
            if (wr_en_s[i]) begin
                mem_q[wr_idx_s[i]] <= bus.retire_tag[i];
            end
        end
    end

    assign bus.retire_ready = ready_q;
    assign bus.stage_count  = stage_count_q;
    assign bus.overflow_err = overflow_q;
    assign bus.put_en       = put_en_s;
    assign bus.put          = put_s;

endmodule
